// File: rtl/ise_pkg.sv
// Shared types and sizing for the image sort engine: colour codes, sort key
// layout and the per-image accumulator widths.
package ise_pkg;

   typedef enum logic [1:0] {
      RED   = 2'd0,
      GREEN = 2'd1,
      BLUE  = 2'd2
   } color_e;

   typedef enum logic [2:0] {
      S_ACC,
      S_DIV,
      S_INSERT,
      S_OUTPUT,
      S_DONE
   } state_e;

   localparam int IMAGE_SIZE_NOM = 128;
   localparam int PIX_PER_IMG    = IMAGE_SIZE_NOM * IMAGE_SIZE_NOM;
   localparam int SUM_W          = 22;
   localparam int CNT_W          = 15;
   localparam int AVG_W          = 16;
   localparam int IDX_W          = 5;
   localparam int DIV_N_W        = SUM_W + 8;

   // Field order makes a plain unsigned compare of the packed key the sort order.
   typedef struct packed {
      color_e             color;
      logic [AVG_W-1:0]   avg;
      logic [IDX_W-1:0]   index;
   } sort_key_t;

   // Largest value wins; ties resolve red, then green, then blue.
   function automatic color_e pick_color(input logic [CNT_W-1:0] r,
                                         input logic [CNT_W-1:0] g,
                                         input logic [CNT_W-1:0] b);
      color_e res;
      if (r >= g && r >= b)
         res = RED;
      else if (g >= b)
         res = GREEN;
      else
         res = BLUE;
      return res;
   endfunction

endpackage

// File: rtl/ise_divider.sv
// Serial restoring divider: one quotient bit per cycle over the full dividend
// width, single-cycle done pulse when the quotient is ready.
module ise_divider
   import ise_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [DIV_N_W-1:0] dividend,
   input  logic [CNT_W-1:0]   divisor,
   output logic               done,
   output logic [AVG_W-1:0]   quotient
);

   logic [CNT_W-1:0]   rem_reg;
   logic [DIV_N_W-1:0] quo_reg;
   logic [CNT_W-1:0]   dsr_reg;
   logic [4:0]         iter_reg;
   logic               run_reg;
   logic               done_reg;

   logic [CNT_W:0]     shifted;
   logic               fits;
   logic [CNT_W-1:0]   diff;

   assign shifted = {rem_reg, quo_reg[DIV_N_W-1]};
   assign fits    = shifted >= {1'b0, dsr_reg};
   // When fits is set the true difference is below the divisor, so modulo
   // arithmetic on the low bits is exact.
   assign diff    = shifted[CNT_W-1:0] - dsr_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         dsr_reg  <= '0;
         iter_reg <= '0;
         run_reg  <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dsr_reg  <= divisor;
            iter_reg <= 5'(DIV_N_W);
            run_reg  <= 1'b1;
         end else if (run_reg) begin
            rem_reg  <= fits ? diff : shifted[CNT_W-1:0];
            quo_reg  <= {quo_reg[DIV_N_W-2:0], fits};
            iter_reg <= iter_reg - 5'd1;
            if (iter_reg == 5'd1) begin
               run_reg  <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done     = done_reg;
   assign quotient = quo_reg[AVG_W-1:0];

endmodule

// File: rtl/image_sort_engine.sv
// Streaming RGB image classifier: accumulates per-image colour statistics,
// averages the dominant colour and emits image indices in sorted key order.
module image_sort_engine
   import ise_pkg::*;
#(
   parameter int IMAGE_NUM  = 32,
   parameter int IMAGE_SIZE = IMAGE_SIZE_NOM
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] image_in_index,
   input  logic [23:0]      pixel_in,
   output logic             busy,
   output logic             out_valid,
   output logic [1:0]       color_index,
   output logic [IDX_W-1:0] image_out_index
);

   // Accumulator widths are sized for the nominal image; larger edges clamp.
   localparam int PIX_N = (IMAGE_SIZE * IMAGE_SIZE > PIX_PER_IMG) ?
                          PIX_PER_IMG : IMAGE_SIZE * IMAGE_SIZE;

   state_e           state_reg;
   logic             busy_reg;
   logic             out_valid_reg;
   logic [1:0]       color_reg;
   logic [IDX_W-1:0] out_index_reg;
   logic [CNT_W-1:0] pix_cnt_reg;
   logic [IDX_W-1:0] img_cnt_reg;
   logic [IDX_W-1:0] out_cnt_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [CNT_W-1:0] cnt_reg [3];
   logic [SUM_W-1:0] sum_reg [3];
   logic             div_start_reg;
   sort_key_t        key_reg;
   sort_key_t        list_reg [IMAGE_NUM];
   logic [IMAGE_NUM-1:0] valid_reg;

   logic [7:0]       chan [3];
   color_e           pix_color;
   color_e           dom_color;
   logic             div_done;
   logic [AVG_W-1:0] div_quo;
   logic [IMAGE_NUM-1:0] gt;
   sort_key_t        ins_list [IMAGE_NUM];
   sort_key_t        shl_list [IMAGE_NUM];

   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = pixel_in[23-8*gi -: 8];
   end

   assign pix_color = pick_color(CNT_W'(chan[0]), CNT_W'(chan[1]), CNT_W'(chan[2]));
   assign dom_color = pick_color(cnt_reg[0], cnt_reg[1], cnt_reg[2]);

   ise_divider u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start_reg),
      .dividend ({sum_reg[dom_color], 8'd0}),
      .divisor  (cnt_reg[dom_color]),
      .done     (div_done),
      .quotient (div_quo)
   );

   // Sorted list: gt marks slots whose occupant moves down one place; the
   // first such slot receives the new key.
   for (genvar gi = 0; gi < IMAGE_NUM; gi++) begin : g_list
      assign gt[gi] = !valid_reg[gi] || (list_reg[gi] > key_reg);
      if (gi == 0) begin : g_head
         assign ins_list[gi] = gt[gi] ? key_reg : list_reg[gi];
      end else begin : g_body
         assign ins_list[gi] = !gt[gi]    ? list_reg[gi]   :
                               gt[gi-1]   ? list_reg[gi-1] : key_reg;
      end
      if (gi == IMAGE_NUM - 1) begin : g_tail
         assign shl_list[gi] = '0;
      end else begin : g_shift
         assign shl_list[gi] = list_reg[gi+1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_ACC;
         busy_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         color_reg     <= '0;
         out_index_reg <= '0;
         pix_cnt_reg   <= '0;
         img_cnt_reg   <= '0;
         out_cnt_reg   <= '0;
         idx_reg       <= '0;
         div_start_reg <= 1'b0;
         key_reg       <= '0;
         valid_reg     <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_reg[i] <= '0;
            sum_reg[i] <= '0;
         end
         for (int i = 0; i < IMAGE_NUM; i++) begin
            list_reg[i] <= '0;
         end
      end else begin
         div_start_reg <= 1'b0;
         case (state_reg)
            S_ACC: begin
               cnt_reg[pix_color] <= cnt_reg[pix_color] + CNT_W'(1);
               sum_reg[pix_color] <= sum_reg[pix_color] + SUM_W'(chan[pix_color]);
               idx_reg            <= image_in_index;
               if (pix_cnt_reg == CNT_W'(PIX_N - 1)) begin
                  pix_cnt_reg   <= '0;
                  busy_reg      <= 1'b1;
                  div_start_reg <= 1'b1;
                  state_reg     <= S_DIV;
               end else begin
                  pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
               end
            end
            S_DIV: begin
               if (div_done) begin
                  key_reg   <= '{color: dom_color, avg: div_quo, index: idx_reg};
                  state_reg <= S_INSERT;
               end
            end
            S_INSERT: begin
               for (int i = 0; i < IMAGE_NUM; i++) begin
                  list_reg[i] <= ins_list[i];
               end
               valid_reg <= {valid_reg[IMAGE_NUM-2:0], 1'b1};
               for (int i = 0; i < 3; i++) begin
                  cnt_reg[i] <= '0;
                  sum_reg[i] <= '0;
               end
               if (img_cnt_reg == IDX_W'(IMAGE_NUM - 1)) begin
                  img_cnt_reg <= '0;
                  state_reg   <= S_OUTPUT;
               end else begin
                  img_cnt_reg <= img_cnt_reg + IDX_W'(1);
                  busy_reg    <= 1'b0;
                  state_reg   <= S_ACC;
               end
            end
            S_OUTPUT: begin
               out_valid_reg <= 1'b1;
               color_reg     <= list_reg[0].color;
               out_index_reg <= list_reg[0].index;
               for (int i = 0; i < IMAGE_NUM; i++) begin
                  list_reg[i] <= shl_list[i];
               end
               out_cnt_reg <= out_cnt_reg + IDX_W'(1);
               if (out_cnt_reg == IDX_W'(IMAGE_NUM - 1)) begin
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               out_valid_reg <= 1'b0;
               color_reg     <= '0;
               out_index_reg <= '0;
            end
            default: state_reg <= S_ACC;
         endcase
      end
   end

   assign busy            = busy_reg;
   assign out_valid       = out_valid_reg;
   assign color_index     = color_reg;
   assign image_out_index = out_index_reg;

endmodule

// File: tb/tb_image_sort_engine.sv
// Scoreboard bench for image_sort_engine using a reduced image edge so full
// 32-image runs stay short.
module tb_image_sort_engine;

   localparam int IMG_SIZE = 8;
   localparam int PIX      = IMG_SIZE * IMG_SIZE;
   localparam int NIMG     = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  image_in_index = '0;
   logic [23:0] pixel_in = '0;
   logic        busy;
   logic        out_valid;
   logic [1:0]  color_index;
   logic [4:0]  image_out_index;

   image_sort_engine #(.IMAGE_NUM(NIMG), .IMAGE_SIZE(IMG_SIZE)) dut (
      .clk             (clk),
      .reset           (reset),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .busy            (busy),
      .out_valid       (out_valid),
      .color_index     (color_index),
      .image_out_index (image_out_index)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [6:0]  exp_q[$];
   bit          mon_en = 1'b1;
   int          run_len = 0;
   int          n_pops = 0;
   logic [6:0]  mon_exp;
   logic [23:0] img_a [NIMG];
   logic [23:0] img_b [NIMG];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: every valid output entry is matched against the queue head.
   always @(negedge clk) begin
      if (!mon_en) begin
         run_len = 0;
      end else if (out_valid) begin
         run_len++;
         if (exp_q.size() == 0) begin
            check("out_unexpected", 32'(out_valid), 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            n_pops++;
            $display("out #%0d: color=%0d index=%0d (exp %0d/%0d)", run_len,
                     color_index, image_out_index, mon_exp[6:5], mon_exp[4:0]);
            check("out_color", 32'(color_index), 32'(mon_exp[6:5]));
            check("out_index", 32'(image_out_index), 32'(mon_exp[4:0]));
         end
      end else if (run_len != 0) begin
         check("burst_len", 32'(run_len), 32'(NIMG));
         check("idle_outputs", {25'd0, color_index, image_out_index}, 32'd0);
         run_len = 0;
      end
   end

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_color", 32'(color_index), 32'd0);
      check("rst_index", 32'(image_out_index), 32'd0);
      reset = 1'b0;
   endtask

   // Pixels held during busy are a bright junk value that must not be counted.
   task automatic send_image(input int idx, input bit last);
      int n;
      for (int p = 0; p < PIX; p++) begin
         image_in_index = 5'(idx);
         pixel_in       = (p < PIX / 2) ? img_a[idx] : img_b[idx];
         @(posedge clk);
         #1;
      end
      pixel_in = 24'hFFFFFF;
      check("busy_set", 32'(busy), 32'd1);
      if (!last) begin
         n = 0;
         while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
         $display("image %0d: busy window %0d cycles", idx, n);
         check("busy_release", 32'(n <= 34 && !busy), 32'd1);
      end
   endtask

   function automatic logic [22:0] model_key(input int idx);
      int         cnt [3];
      int         sum [3];
      logic [7:0] ch [3];
      logic [23:0] px;
      int         c;
      int         dom;
      int         avg;
      for (int j = 0; j < 3; j++) begin
         cnt[j] = 0;
         sum[j] = 0;
      end
      for (int h = 0; h < 2; h++) begin
         px    = h ? img_b[idx] : img_a[idx];
         ch[0] = px[23:16];
         ch[1] = px[15:8];
         ch[2] = px[7:0];
         if (ch[0] >= ch[1] && ch[0] >= ch[2]) c = 0;
         else if (ch[1] >= ch[2])              c = 1;
         else                                  c = 2;
         cnt[c] += PIX / 2;
         sum[c] += (PIX / 2) * int'(ch[c]);
      end
      if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) dom = 0;
      else if (cnt[1] >= cnt[2])                dom = 1;
      else                                      dom = 2;
      avg = (sum[dom] * 256) / cnt[dom];
      return {dom[1:0], avg[15:0], idx[4:0]};
   endfunction

   task automatic push_model();
      logic [22:0] k [NIMG];
      logic [22:0] t;
      for (int i = 0; i < NIMG; i++) k[i] = model_key(i);
      for (int i = 0; i < NIMG - 1; i++) begin
         for (int j = 0; j < NIMG - 1 - i; j++) begin
            if (k[j] > k[j+1]) begin
               t      = k[j];
               k[j]   = k[j+1];
               k[j+1] = t;
            end
         end
      end
      for (int i = 0; i < NIMG; i++) exp_q.push_back({k[i][22:21], k[i][4:0]});
   endtask

   task automatic send_all();
      for (int i = 0; i < NIMG; i++) send_image(i, i == NIMG - 1);
   endtask

   task automatic wait_burst();
      int n = 0;
      while ((exp_q.size() != 0 || run_len != 0) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("burst_done", 32'(n < 400), 32'd1);
   endtask

   task automatic randomize_images();
      for (int i = 0; i < NIMG; i++) begin
         img_a[i] = 24'($urandom);
         img_b[i] = 24'($urandom);
      end
   endtask

   initial begin
      int base;
      int n;

      do_reset(2);

      // Run 1: two red images, everything else pure blue.
      for (int i = 0; i < NIMG; i++) begin
         img_a[i] = 24'h0000FF;
         img_b[i] = 24'h0000FF;
      end
      img_a[3] = 24'h100000; img_b[3] = 24'h100000;
      img_a[1] = 24'h200000; img_b[1] = 24'h200000;
      send_all();
      exp_q.push_back({2'd0, 5'd3});
      exp_q.push_back({2'd0, 5'd1});
      for (int i = 0; i < NIMG; i++) begin
         if (i != 1 && i != 3) exp_q.push_back({2'd2, 5'(i)});
      end
      wait_burst();
      repeat (10) @(posedge clk);

      // Run 2: tie cases, exact green average, equal keys, rest random.
      do_reset(2);
      randomize_images();
      img_a[0]  = 24'hFF0000; img_b[0]  = 24'h00FF00;
      img_a[5]  = 24'h004000; img_b[5]  = 24'h004000;
      img_a[7]  = 24'h808000; img_b[7]  = 24'h808000;
      img_a[10] = 24'h808000; img_b[10] = 24'h808000;
      img_a[11] = 24'h808000; img_b[11] = 24'h808000;
      img_a[9]  = 24'h555555; img_b[9]  = 24'h555555;
      send_all();
      push_model();
      wait_burst();

      // Reset in the middle of an image.
      do_reset(1);
      for (int p = 0; p < 20; p++) begin
         image_in_index = 5'd4;
         pixel_in       = 24'hFF0000;
         @(posedge clk);
         #1;
      end
      do_reset(1);

      // Run 3: abort partway through the output burst.
      randomize_images();
      send_all();
      push_model();
      base = n_pops;
      n    = 0;
      while (n_pops < base + 5 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort_reached", 32'(n < 400), 32'd1);
      mon_en = 1'b0;
      exp_q.delete();
      do_reset(1);
      mon_en = 1'b1;

      // Run 4: fresh random run after the aborted one.
      randomize_images();
      send_all();
      push_model();
      wait_burst();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
